starfield_gen: RTL and testbench
================================

Name: starfield_gen

Overview:
- Downstream pixel-source stage fed directly by the display timing generator (pixel_x, pixel_y, hsync, vsync, video_on).
- Produces a vertically scrolling, deterministic pseudo-random starfield as 24-bit RGB, using one LFSR re-seeded per line.
- Delays hsync, vsync and data-enable so they stay aligned with the RGB output.
- Feeds the game compositor / HDMI encoder.

Parameters:
- SEED, 16'hACE1, base LFSR seed, XORed with the scrolled row number.
- DENSITY_BITS, 6, number of LFSR MSBs that must all be 1 to light a star (density = 2^-DENSITY_BITS); legal range 1..12.
- SCROLL_SPEED, 1, rows added to the scroll offset per frame (10-bit, unsigned).
- PIPE_LAT, 2, fixed latency in vtg_clk cycles; not overridable, documented for integrators.

Ports:
- vtg_clk, input, 1, pixel clock domain (gated pixel clock).
- reset, input, 1, reset, asynchronous, active-high; clock vtg_clk.
- pixel_x, input, 10, current horizontal count.
- pixel_y, input, 10, current vertical count.
- hsync_in, input, 1, horizontal sync from timing.
- vsync_in, input, 1, vertical sync from timing.
- video_on, input, 1, visible-area flag.
- scroll_en, input, 1, 1 = advance scroll at each frame edge; 0 = freeze.
- rgb_out, output, 24, {R[7:0],G[7:0],B[7:0]}.
- de_out, output, 1, video_on delayed by PIPE_LAT.
- hsync_out, output, 1, hsync_in delayed by PIPE_LAT.
- vsync_out, output, 1, vsync_in delayed by PIPE_LAT.
- frame_cnt, output, 8, frames since reset; wraps 255 -> 0.

Behaviour:
- Reset (async): rgb_out, de_out, hsync_out and vsync_out are 0. frame_cnt = 0, scroll = 0, lfsr = 16'h0001, vsync_prev = 0, state = WAIT_SYNC.
- Frame edge: vsync_in = 1 while vsync_prev = 0. vsync_prev is registered every cycle.
- FSM, WAIT_SYNC:
  - rgb_out is forced to 0; syncs and de still pass through the delay line.
  - On the first frame edge, go to ACTIVE. No scroll or frame_cnt update on that edge.
- FSM, ACTIVE:
  - On each frame edge, frame_cnt++.
  - If scroll_en is 1, scroll <= scroll + SCROLL_SPEED (10-bit wrap, 1023+1 = 0).
  - Stays in ACTIVE until reset.
- Row: row = pixel_y + scroll, 10-bit modular.
- Seed: seed = SEED ^ {6'b0,row}. If seed == 0, load 16'h0001 instead (zero-lockout guard).
- LFSR, stage 0:
  - pixel_x == 0: lfsr <= seed. This takes priority over stepping.
  - Else if video_on == 1: lfsr <= Galois step, polynomial x^16+x^14+x^13+x^11+1 (shift right; if the old bit0 was 1, XOR with 16'hB400).
  - Else: hold.
- Stage 1 registers:
  - star = &lfsr[15:16-DENSITY_BITS].
  - intensity = {lfsr[2:0], 5'h1F}.
  - The registered video_on, hsync_in and vsync_in.
- Stage 2 registers:
  - rgb_out = (state == ACTIVE && de_s1 && star_s1) ? {intensity, intensity, intensity} : 24'h0.
  - de_out, hsync_out and vsync_out take their stage-1 values.
- Latency: an input sampled at cycle t appears on the outputs at t+2, for every output except frame_cnt.
- frame_cnt updates on the cycle after the frame edge; it is not pipeline-delayed.
- Mid-frame reset: all of the above reset values apply immediately. After release, the block is black until the next frame edge.
- Simultaneous pixel_x == 0 and video_on == 1: load wins; the first visible pixel uses the seed itself.

Optional Feature:
- Macro: STARFIELD_TWINKLE_EN.
- When defined: intensity = {lfsr[2:0] ^ frame_cnt[4:2], 5'h1F}, so star brightness changes every 4 frames while star positions are unchanged.
- When undefined: intensity as in Behaviour; the output is identical across frames whenever scroll is frozen.

Decomposition:
- Package starsoc_params (shared):
  - LFSR_TAPS = 16'hB400.
  - LFSR_W = 16.
  - RGB_W = 24.
  - typedef enum logic {WAIT_SYNC, ACTIVE} sf_state_t.
  - typedef logic [23:0] rgb_t.
- One sub-module: star_lfsr. It holds the 16-bit Galois LFSR with load/step/hold controls and the zero-lockout guard. It is reused by future noise/explosion effects.

Test Plan:
- Reset check: assert reset mid-line with video_on = 1 -> all outputs 0 in the same cycle; rgb_out stays 0 after release until the first vsync_in rising edge.
- Latency alignment: drive video_on 0->1 at cycle 100 -> de_out rises at cycle 102; hsync_in pulse at 200..295 -> hsync_out at 202..297.
- Scroll wrap: SCROLL_SPEED = 1, scroll_en = 1, 1025 frame edges after the first -> scroll returns to 1. The line-0 pixel stream of frame k+1 equals the line-1 stream of frame k.
- Freeze / determinism: scroll_en = 0 over 3 frames, macro undefined -> bit-identical rgb_out streams each frame; frame_cnt increments 1, 2, 3.
- Seed lockout: SEED = 16'h0000, pixel_y = 0, scroll = 0 -> lfsr loads 16'h0001. First step gives 16'hB400; second step gives 16'h5A00.
- Density: DENSITY_BITS = 1 over one 640x480 frame -> about 50% star pixels (±2%). Every lit pixel has R = G = B, with a low 5-bit field of 5'h1F.

Source files
------------

// File: rtl/starfield_gen_pkg.sv
// Shared constants and types for the star/noise video effect blocks.
// Holds the LFSR polynomial and the pixel format used between effect stages.
package starsoc_params;

  localparam int                LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int                RGB_W     = 24;

  typedef enum logic {WAIT_SYNC, ACTIVE} sf_state_t;
  typedef logic [RGB_W-1:0] rgb_t;

  // One right-shift Galois step of x^16+x^14+x^13+x^11+1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/starfield_gen_if.sv
// Timing-generator inputs and video outputs of the starfield source.
// master = timing side / downstream consumer, slave = starfield_gen.
interface starfield_gen_if;
  import starsoc_params::*;

  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       hsync_in;
  logic       vsync_in;
  logic       video_on;
  logic       scroll_en;
  rgb_t       rgb_out;
  logic       de_out;
  logic       hsync_out;
  logic       vsync_out;
  logic [7:0] frame_cnt;

  modport master (
    output pixel_x, pixel_y, hsync_in, vsync_in, video_on, scroll_en,
    input  rgb_out, de_out, hsync_out, vsync_out, frame_cnt
  );

  modport slave (
    input  pixel_x, pixel_y, hsync_in, vsync_in, video_on, scroll_en,
    output rgb_out, de_out, hsync_out, vsync_out, frame_cnt
  );

endinterface

// File: rtl/starfield_gen_star_lfsr.sv
// 16-bit Galois LFSR with load/step/hold and zero-seed lockout guard.
// The next value is exported so callers can register it alongside their own pipeline.
module star_lfsr
  import starsoc_params::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] nxt
);

  logic [LFSR_W-1:0] q;
  logic [LFSR_W-1:0] seed_safe;

  always_comb begin
    // An all-zero state would stick forever.
    seed_safe = (seed == '0) ? LFSR_W'(1) : seed;
    nxt       = q;
    if (load) begin
      nxt = seed_safe;
    end else if (step) begin
      nxt = lfsr_step(q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= LFSR_W'(1);
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/starfield_gen.sv
// Scrolling pseudo-random starfield pixel source; 2-cycle latency on rgb/de/syncs, no backpressure.
// Define STARFIELD_TWINKLE_EN to modulate star brightness with frame_cnt[4:2].
module starfield_gen
  import starsoc_params::*;
#(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          DENSITY_BITS = 6,
  parameter logic [9:0]  SCROLL_SPEED = 10'd1
) (
  input  logic           vtg_clk,
  input  logic           reset,
  starfield_gen_if.slave vid
);

  localparam int PIPE_LAT = 2;

  sf_state_t           state;
  sf_state_t           state_nxt;
  logic                vsync_prev;
  logic                frame_edge;
  logic [7:0]          frame_cnt;
  logic [7:0]          frame_cnt_nxt;
  logic [9:0]          scroll;
  logic [9:0]          scroll_nxt;
  logic [9:0]          row;
  logic [LFSR_W-1:0]   seed;
  logic [LFSR_W-1:0]   lfsr_nxt;
  logic [7:0]          intensity;
  logic                star_s1;
  logic [7:0]          intensity_s1;
  logic [PIPE_LAT-1:0] de_pipe;
  logic [PIPE_LAT-1:0] hs_pipe;
  logic [PIPE_LAT-1:0] vs_pipe;
  rgb_t                rgb;

  assign frame_edge = vid.vsync_in & ~vsync_prev;
  assign row        = vid.pixel_y + scroll;
  assign seed       = SEED ^ {6'b0, row};

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    scroll_nxt    = scroll;
    case (state)
      // The first frame edge only arms the block; counting starts on the next one.
      WAIT_SYNC: if (frame_edge) state_nxt = ACTIVE;
      ACTIVE: begin
        if (frame_edge) begin
          frame_cnt_nxt = frame_cnt + 8'd1;
          if (vid.scroll_en) begin
            scroll_nxt = scroll + SCROLL_SPEED;
          end
        end
      end
    endcase
  end

  always_ff @(posedge vtg_clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_SYNC;
      vsync_prev <= 1'b0;
      frame_cnt  <= 8'd0;
      scroll     <= 10'd0;
    end else begin
      state      <= state_nxt;
      vsync_prev <= vid.vsync_in;
      frame_cnt  <= frame_cnt_nxt;
      scroll     <= scroll_nxt;
    end
  end

  star_lfsr u_lfsr (
    .clk   (vtg_clk),
    .reset (reset),
    .load  (vid.pixel_x == 10'd0),
    .step  (vid.video_on),
    .seed  (seed),
    .nxt   (lfsr_nxt)
  );

`ifdef STARFIELD_TWINKLE_EN
  assign intensity = {lfsr_nxt[2:0] ^ frame_cnt[4:2], 5'h1F};
`else
  assign intensity = {lfsr_nxt[2:0], 5'h1F};
`endif

  // Stage 1 samples the LFSR value belonging to the same pixel as the syncs.
  always_ff @(posedge vtg_clk or posedge reset) begin
    if (reset) begin
      star_s1      <= 1'b0;
      intensity_s1 <= 8'd0;
      de_pipe      <= '0;
      hs_pipe      <= '0;
      vs_pipe      <= '0;
      rgb          <= '0;
    end else begin
      star_s1      <= &lfsr_nxt[LFSR_W-1 -: DENSITY_BITS];
      intensity_s1 <= intensity;
      de_pipe      <= {de_pipe[PIPE_LAT-2:0], vid.video_on};
      hs_pipe      <= {hs_pipe[PIPE_LAT-2:0], vid.hsync_in};
      vs_pipe      <= {vs_pipe[PIPE_LAT-2:0], vid.vsync_in};
      rgb          <= (state == ACTIVE && de_pipe[0] && star_s1) ?
                      {intensity_s1, intensity_s1, intensity_s1} : '0;
    end
  end

  assign vid.rgb_out   = rgb;
  assign vid.de_out    = de_pipe[PIPE_LAT-1];
  assign vid.hsync_out = hs_pipe[PIPE_LAT-1];
  assign vid.vsync_out = vs_pipe[PIPE_LAT-1];
  assign vid.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_starfield_gen.sv
// Bench for starfield_gen: delay-line table, reset/lockout/wrap sequences, and a
// frame-level reference model checked every cycle on two parameterisations.
module tb_starfield_gen;
  import starsoc_params::*;

  localparam int HTOT = 80, HVIS = 64, HS_B = 68, HS_E = 72;
  localparam int VTOT = 12, VVIS = 8,  VS_B = 9,  VS_E = 11;

  logic vtg_clk = 1'b0;
  logic reset   = 1'b1;

  starfield_gen_if vid0 ();
  starfield_gen_if vid1 ();

  starfield_gen dut0 (.vtg_clk(vtg_clk), .reset(reset), .vid(vid0));
  starfield_gen #(.SEED(16'h0000), .DENSITY_BITS(1), .SCROLL_SPEED(10'd7))
    dut1 (.vtg_clk(vtg_clk), .reset(reset), .vid(vid1));

  always #5 vtg_clk = ~vtg_clk;

  typedef struct { logic [23:0] rgb; logic de; logic hs; logic vs; } exp_t;
  typedef struct { logic active; logic vprev; logic [9:0] scroll; logic [7:0] fcnt; } mdl_t;
  typedef struct { logic von; logic hs; logic vs; logic de_e; logic hs_e; logic vs_e; } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  mdl_t m [2];
  exp_t pipe [2][2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, want);
    end
  endtask

  function automatic logic [15:0] seed_of(input int d);
    return (d == 0) ? 16'hACE1 : 16'h0000;
  endfunction
  function automatic int dens_of(input int d);
    return (d == 0) ? 6 : 1;
  endfunction
  function automatic int speed_of(input int d);
    return (d == 0) ? 1 : 7;
  endfunction

  // LFSR value n visible pixels into a line, from the polynomial definition.
  function automatic logic [15:0] lfsr_at(input logic [15:0] seed, input int n);
    logic [15:0] v;
    v = (seed == 16'h0) ? 16'h0001 : seed;
    for (int i = 0; i < n; i++) begin
      if (v[0]) v = (v >> 1) ^ 16'hB400;
      else      v = v >> 1;
    end
    return v;
  endfunction

  function automatic exp_t act_of(input int d);
    exp_t a;
    if (d == 0) begin
      a.rgb = vid0.rgb_out; a.de = vid0.de_out; a.hs = vid0.hsync_out; a.vs = vid0.vsync_out;
    end else begin
      a.rgb = vid1.rgb_out; a.de = vid1.de_out; a.hs = vid1.hsync_out; a.vs = vid1.vsync_out;
    end
    return a;
  endfunction

  function automatic logic [7:0] fcnt_of(input int d);
    return (d == 0) ? vid0.frame_cnt : vid1.frame_cnt;
  endfunction

  function automatic logic gray_ok(input logic [23:0] c);
    return (c[23:16] == c[15:8]) && (c[15:8] == c[7:0]) && (c[4:0] == 5'h1F);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m[d].active = 1'b0; m[d].vprev = 1'b0; m[d].scroll = 10'd0; m[d].fcnt = 8'd0;
      for (int k = 0; k < 2; k++) begin
        pipe[d][k].rgb = 24'h0; pipe[d][k].de = 1'b0; pipe[d][k].hs = 1'b0; pipe[d][k].vs = 1'b0;
      end
    end
  endtask

  task automatic model_step(input int d, input int x, input int y, input logic hs,
                            input logic vs, input logic von, input logic sen);
    exp_t        e;
    logic [9:0]  row;
    logic [15:0] v;
    int          dens, top;
    row = 10'((y + int'(m[d].scroll)) % 1024);
    if (vs && !m[d].vprev) begin
      if (m[d].active) begin
        m[d].fcnt = m[d].fcnt + 8'd1;
        if (sen) m[d].scroll = 10'((int'(m[d].scroll) + speed_of(d)) % 1024);
      end else begin
        m[d].active = 1'b1;
      end
    end
    m[d].vprev = vs;
    v    = lfsr_at(seed_of(d) ^ {6'b0, row}, x);
    dens = dens_of(d);
    top  = int'(v) >> (16 - dens);
    e.rgb = 24'h0;
    if (m[d].active && von && top == (1 << dens) - 1) e.rgb = {3{v[2:0], 5'h1F}};
    e.de = von; e.hs = hs; e.vs = vs;
    pipe[d][0] = e;
  endtask

  task automatic compare_outputs();
    exp_t a, e;
    for (int d = 0; d < 2; d++) begin
      a = act_of(d);
      e = pipe[d][1];
      check($sformatf("rgb_out[%0d]", d),   32'(a.rgb), 32'(e.rgb));
      check($sformatf("de_out[%0d]", d),    32'(a.de),  32'(e.de));
      check($sformatf("hsync_out[%0d]", d), 32'(a.hs),  32'(e.hs));
      check($sformatf("vsync_out[%0d]", d), 32'(a.vs),  32'(e.vs));
      check($sformatf("frame_cnt[%0d]", d), 32'(fcnt_of(d)), 32'(m[d].fcnt));
      if (a.rgb != 24'h0) check($sformatf("gray_star[%0d]", d), 32'(gray_ok(a.rgb)), 32'd1);
      pipe[d][1] = pipe[d][0];
    end
  endtask

  task automatic set_in(input int x, input int y, input logic hs, input logic vs,
                        input logic von, input logic sen);
    vid0.pixel_x = 10'(x); vid0.pixel_y = 10'(y); vid0.hsync_in = hs; vid0.vsync_in = vs;
    vid0.video_on = von;   vid0.scroll_en = sen;
    vid1.pixel_x = 10'(x); vid1.pixel_y = 10'(y); vid1.hsync_in = hs; vid1.vsync_in = vs;
    vid1.video_on = von;   vid1.scroll_en = sen;
  endtask

  // Called on a falling edge: check what is due, then present the next pixel.
  task automatic apply(input int x, input int y, input logic hs, input logic vs,
                       input logic von, input logic sen);
    compare_outputs();
    set_in(x, y, hs, vs, von, sen);
    model_step(0, x, y, hs, vs, von, sen);
    model_step(1, x, y, hs, vs, von, sen);
  endtask

  task automatic px_apply(input int x, input int y, input logic sen);
    apply(x, y, (x >= HS_B && x < HS_E), (y >= VS_B && y < VS_E), (x < HVIS && y < VVIS), sen);
  endtask

  task automatic drive_px(input int x, input int y, input logic sen);
    @(negedge vtg_clk);
    px_apply(x, y, sen);
  endtask

  task automatic run_frame(input int start, input logic sen);
    for (int i = start; i < HTOT * VTOT; i++) drive_px(i % HTOT, i / HTOT, sen);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      exp_t a;
      a = act_of(d);
      check($sformatf("%s rgb[%0d]", tag, d), 32'(a.rgb), 32'd0);
      check($sformatf("%s de[%0d]", tag, d),  32'(a.de),  32'd0);
      check($sformatf("%s hs[%0d]", tag, d),  32'(a.hs),  32'd0);
      check($sformatf("%s vs[%0d]", tag, d),  32'(a.vs),  32'd0);
      check($sformatf("%s fcnt[%0d]", tag, d), 32'(fcnt_of(d)), 32'd0);
    end
  endtask

  task automatic reset_pulse();
    @(negedge vtg_clk);
    reset = 1'b1;
    set_in(HTOT - 1, VTOT - 1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge vtg_clk);
    model_reset();
    reset = 1'b0;
    apply(HTOT - 1, VTOT - 1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted in the middle of a visible line must clear outputs at once.
  task automatic mid_reset(input int x, input int y, input logic sen);
    drive_px(x, y, sen);
    #2 reset = 1'b1;
    #1 check_zero("midreset");
    repeat (2) @(negedge vtg_clk);
    model_reset();
    @(negedge vtg_clk);
    reset = 1'b0;
    px_apply(x + 1, y, sen);
    run_frame(y * HTOT + x + 2, sen);
  endtask

  task automatic lockout_frame(input logic sen);
    logic [15:0] want [3];
    want[0] = 16'h0001; want[1] = 16'hB400; want[2] = 16'h5A00;
    for (int x = 0; x < 3; x++) begin
      drive_px(x, 0, sen);
      @(posedge vtg_clk);
      #1 check("seed_lockout", 32'(dut1.u_lfsr.q), 32'(want[x]));
    end
    run_frame(3, sen);
  endtask

  initial begin
    vec_t tbl [10];
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    set_in(HTOT - 1, VTOT - 1, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(negedge vtg_clk);
    check_zero("reset");
    reset = 1'b0;
    apply(HTOT - 1, VTOT - 1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge vtg_clk);
      apply(HTOT - 1, VTOT - 1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Delay-line vectors while still waiting for the first frame edge.
    for (int i = 0; i < 10; i++) begin
      @(negedge vtg_clk);
      check("tbl_de",   32'(vid0.de_out),    32'(tbl[i].de_e));
      check("tbl_hs",   32'(vid0.hsync_out), 32'(tbl[i].hs_e));
      check("tbl_vs",   32'(vid0.vsync_out), 32'(tbl[i].vs_e));
      check("tbl_rgb",  32'(vid0.rgb_out),   32'd0);
      check("tbl_fcnt", 32'(vid0.frame_cnt), 32'd0);
      set_in(5, 0, tbl[i].hs, tbl[i].vs, tbl[i].von, 1'b1);
    end

    reset_pulse();
    run_frame(0, 1'($urandom_range(0, 1)));
    lockout_frame(1'b0);
    repeat (3) run_frame(0, 1'b0);
    repeat (4) run_frame(0, 1'($urandom_range(0, 1)));

    mid_reset(10, 3, 1'b1);
    repeat (2) run_frame(0, 1'($urandom_range(0, 1)));

    // Scroll wrap: 1025 counted frame edges at speed 1 bring scroll back to 1.
    reset_pulse();
    run_frame(0, 1'b1);
    for (int k = 0; k < 1025; k++) begin
      @(negedge vtg_clk);
      apply(HTOT - 1, VTOT - 1, 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge vtg_clk);
      apply(HTOT - 1, VTOT - 1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    @(negedge vtg_clk);
    check("scroll_wrap", 32'(dut0.scroll), 32'd1);
    px_apply(0, 0, 1'b1);
    run_frame(1, 1'b1);
    run_frame(0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
